// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter that shares one multiplier_fp between
// NUM_REQ requesters. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional watchdog enabled by defining FPMUL_ARB_TIMEOUT_EN; when it fires, the
// granted requester receives a NaN result flagged with resp_err.
module fp_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*32-1:0]   a_in,
   input  logic [NUM_REQ*32-1:0]   b_in,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [31:0]             resp_y,
   output logic                    resp_err,
   output logic                    mul_start,
   output logic [31:0]             mul_a,
   output logic [31:0]             mul_b,
   input  logic                    mul_ready,
   input  logic                    mul_busy,
   input  logic [31:0]             mul_y
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [31:0] NAN_Y = 32'h7F80_0001;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [IDW-1:0]     r_last;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_resp_valid;
   logic [31:0]        r_resp_y;
   logic               r_resp_err;
   logic               r_mul_start;
   logic [31:0]        r_mul_a;
   logic [31:0]        r_mul_b;

   logic               w_found;
   logic [IDW-1:0]     w_pick;
   logic [IDW-1:0]     w_scan;
   logic               w_grant;
   logic               w_resp;
   logic               w_timeout;

   // Round-robin pick: first asserted request starting just after the last winner.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_scan  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_scan = IDW'((int'(r_last) + k) % NUM_REQ);
         if (!w_found && req[w_scan]) begin
            w_found = 1'b1;
            w_pick  = w_scan;
         end
      end
   end

`ifdef FPMUL_ARB_TIMEOUT_EN
   logic [7:0] r_wdog;

   // Watchdog: restarts on entry to WAIT, counts every WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wdog <= 8'd0;
      else if (r_state == S_ISSUE)
         r_wdog <= 8'd0;
      else if (r_state == S_WAIT)
         r_wdog <= r_wdog + 8'd1;
   end

   // A real ready pulse in the last allowed cycle wins over the watchdog.
   assign w_timeout = (r_state == S_WAIT) && !mul_ready &&
                      (r_wdog == 8'(TIMEOUT_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Grant only from IDLE with a free multiplier; a leftover op keeps us waiting.
   assign w_grant = (r_state == S_IDLE) && w_found && !mul_busy;
   // Ready outside WAIT is ignored, which also drops stale pulses after reset.
   assign w_resp  = (r_state == S_WAIT) && (mul_ready || w_timeout);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nx;
   end

   // Next-state logic.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nx = S_ISSUE;
         S_ISSUE: w_state_nx = S_WAIT;
         S_WAIT:  if (w_resp) w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Grant, start and response strobes; gnt spans grant through the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt        <= '0;
         r_last       <= IDW'(NUM_REQ - 1);
         r_mul_start  <= 1'b0;
         r_resp_valid <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_mul_start  <= w_grant;
         r_resp_valid <= w_resp ? r_gnt : '0;
         r_resp_err   <= w_resp && w_timeout;
         if (w_grant) begin
            r_gnt  <= NUM_REQ'(1) << w_pick;
            r_last <= w_pick;
         end else if (r_state == S_DONE) begin
            r_gnt  <= '0;
         end
      end
   end

   // Operands latched at grant and frozen until the next grant; result latched on response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_a  <= 32'h0;
         r_mul_b  <= 32'h0;
         r_resp_y <= 32'h0;
      end else begin
         if (w_grant) begin
            r_mul_a <= a_in[32*w_pick +: 32];
            r_mul_b <= b_in[32*w_pick +: 32];
         end
         if (w_resp)
            r_resp_y <= mul_ready ? mul_y : NAN_Y;
      end
   end

   assign gnt        = r_gnt;
   assign resp_valid = r_resp_valid;
   assign resp_y     = r_resp_y;
   assign resp_err   = r_resp_err;
   assign mul_start  = r_mul_start;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios driving a hand-played multiplier,
// literal expectations in the main thread, and a transaction-level model that is
// compared against the DUT on every falling edge.
module tb_fp_mul_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [127:0]  a_in = '0;
   logic [127:0]  b_in = '0;
   logic          mul_ready = 1'b0;
   logic          mul_busy = 1'b0;
   logic [31:0]   mul_y = 32'h0;
   logic [N-1:0]  gnt;
   logic [N-1:0]  resp_valid;
   logic [31:0]   resp_y;
   logic          resp_err;
   logic          mul_start;
   logic [31:0]   mul_a;
   logic [31:0]   mul_b;

   int n_checks = 0;
   int n_errors = 0;

   fp_mul_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .resp_valid(resp_valid), .resp_y(resp_y), .resp_err(resp_err),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_ready(mul_ready), .mul_busy(mul_busy), .mul_y(mul_y)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Golden FP multiply for normal operands with exactly representable products.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) * f2r(b));
   endfunction

   function automatic int rr(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   int          ph = 0;        // 0 free, 1 transaction open, 2 response just delivered
   int          m_last = N - 1;
   int          m_owner = 0;
   int          m_age = 0;
   logic [31:0] m_oa, m_ob, m_exp;
   logic [N-1:0] p_req = '0;
   logic        p_busy = 1'b0, p_ready = 1'b0, p_rst = 1'b0;
   logic [31:0] p_y = '0;
   logic [127:0] p_a = '0, p_b = '0;

   always @(negedge clk) begin
      int id;
      if (!rst_n || !p_rst) begin
         chk("rst_gnt", 32'(gnt), 0);
         chk("rst_resp_valid", 32'(resp_valid), 0);
         chk("rst_mul_start", 32'(mul_start), 0);
         chk("rst_resp_err", 32'(resp_err), 0);
         chk("rst_resp_y", resp_y, 0);
         chk("rst_mul_a", mul_a, 0);
         chk("rst_mul_b", mul_b, 0);
         ph = 0;
         m_last = N - 1;
      end else if (ph == 0) begin
         if (p_req != 0 && !p_busy) begin
            id = rr(m_last, p_req);
            m_owner = id;
            m_last = id;
            m_age = 0;
            m_oa = p_a[32*id +: 32];
            m_ob = p_b[32*id +: 32];
            m_exp = fmul(m_oa, m_ob);
            chk("m_grant", 32'(gnt), 32'(1) << id);
            chk("m_start", 32'(mul_start), 1);
            chk("m_mul_a", mul_a, m_oa);
            chk("m_mul_b", mul_b, m_ob);
            ph = 1;
         end else begin
            chk("m_idle_gnt", 32'(gnt), 0);
            chk("m_idle_start", 32'(mul_start), 0);
            chk("m_idle_resp", 32'(resp_valid), 0);
         end
      end else if (ph == 1) begin
         m_age++;
         chk("m_hold_gnt", 32'(gnt), 32'(1) << m_owner);
         chk("m_hold_start", 32'(mul_start), 0);
         chk("m_hold_a", mul_a, m_oa);
         chk("m_hold_b", mul_b, m_ob);
         if (p_ready && m_age >= 2) begin
            chk("m_resp_valid", 32'(resp_valid), 32'(1) << m_owner);
            chk("m_resp_y", resp_y, p_y);
            chk("m_resp_golden", resp_y, m_exp);
            chk("m_resp_err", 32'(resp_err), 0);
            ph = 2;
`ifdef FPMUL_ARB_TIMEOUT_EN
         end else if (m_age == TO + 1) begin
            chk("m_to_valid", 32'(resp_valid), 32'(1) << m_owner);
            chk("m_to_y", resp_y, 32'h7F800001);
            chk("m_to_err", 32'(resp_err), 1);
            ph = 2;
`endif
         end else begin
            chk("m_wait_resp", 32'(resp_valid), 0);
         end
      end else begin
         chk("m_after_gnt", 32'(gnt), 0);
         chk("m_after_resp", 32'(resp_valid), 0);
         chk("m_after_err", 32'(resp_err), 0);
         chk("m_after_start", 32'(mul_start), 0);
         ph = 0;
      end
      p_req = req; p_busy = mul_busy; p_ready = mul_ready; p_y = mul_y;
      p_a = a_in; p_b = b_in; p_rst = rst_n;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; mul_ready = 1'b0; mul_busy = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_start(output int gid, output logic [31:0] oa, output logic [31:0] ob);
      int n = 0;
      gid = -1;
      while (mul_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("start_seen", 32'(mul_start), 1);
      for (int i = 0; i < N; i++) if (gnt[i]) gid = i;
      oa = mul_a;
      ob = mul_b;
      mul_busy = 1'b1;
   endtask

   task automatic give_ready(input logic [31:0] oa, input logic [31:0] ob,
                             output logic [N-1:0] rv, output logic [31:0] ry, output logic re);
      mul_ready = 1'b1; mul_y = fmul(oa, ob); mul_busy = 1'b0;
      tick();
      mul_ready = 1'b0; mul_y = 32'hDEADBEEF;
      rv = resp_valid; ry = resp_y; re = resp_err;
   endtask

   task automatic serve(input int lat, output int gid, output logic [N-1:0] rv,
                        output logic [31:0] ry, output logic re);
      logic [31:0] oa, ob;
      wait_start(gid, oa, ob);
      repeat (lat) tick();
      give_ready(oa, ob, rv, ry, re);
   endtask

   logic [31:0] op_a [N] = '{32'h40000000, 32'h3FC00000, 32'h3F000000, 32'h41200000};
   logic [31:0] op_b [N] = '{32'h40400000, 32'hC0000000, 32'h3E800000, 32'h3FA00000};
   logic [31:0] lit_y[N] = '{32'h40C00000, 32'hC0400000, 32'h3E000000, 32'h41480000};

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         a_in[32*i +: 32] = op_a[i];
         b_in[32*i +: 32] = op_b[i];
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int gid, cnt;
      logic [N-1:0] rv;
      logic [31:0] ry, oa, ob;
      logic re;
      load_ops();

      // single request
      do_reset();
      req = 4'b0001;
      serve(2, gid, rv, ry, re);
      chk("t1_gid", 32'(gid), 0);
      chk("t1_rv", 32'(rv), 32'h1);
      chk("t1_y", ry, 32'h40C00000);
      chk("t1_err", 32'(re), 0);
      req = '0;
      tick(); tick();

      // all requesting: rotation and per-requester products
      do_reset();
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         serve(1 + j % 3, gid, rv, ry, re);
         chk("t2_gid", 32'(gid), 32'(j % N));
         chk("t2_rv", 32'(rv), 32'(1) << (j % N));
         chk("t2_y", ry, lit_y[j % N]);
      end
      req = '0;
      tick(); tick();

      // late request during WAIT, operands frozen, then rotation favours req[2]
      do_reset();
      req = 4'b0001;
      serve(1, gid, rv, ry, re);
      req = 4'b0010;
      wait_start(gid, oa, ob);
      chk("t3_gid1", 32'(gid), 1);
      tick();
      req = 4'b0111;
      a_in[32 +: 32] = 32'h12345678;
      b_in[32 +: 32] = 32'h9ABCDEF0;
      tick(); tick();
      chk("t3_hold_a", mul_a, 32'h3FC00000);
      chk("t3_hold_b", mul_b, 32'hC0000000);
      give_ready(oa, ob, rv, ry, re);
      chk("t3_rv1", 32'(rv), 32'h2);
      chk("t3_y1", ry, 32'hC0400000);
      req = 4'b0101;
      load_ops();
      wait_start(gid, oa, ob);
      chk("t3_gid2", 32'(gid), 2);
      tick();
      give_ready(oa, ob, rv, ry, re);
      chk("t3_rv2", 32'(rv), 32'h4);
      req = '0;
      tick(); tick();

      // reset during WAIT, stale ready afterwards
      req = 4'b0100;
      wait_start(gid, oa, ob);
      tick();
      rst_n = 1'b0;
      req = 4'b0101;
      tick();
      chk("t4_gnt", 32'(gnt), 0);
      chk("t4_mul_a", mul_a, 0);
      chk("t4_resp_y", resp_y, 0);
      tick();
      rst_n = 1'b1;
      tick();
      mul_ready = 1'b1; mul_y = 32'h3F800000; mul_busy = 1'b0;
      tick();
      mul_ready = 1'b0;
      chk("t4_stale_rv", 32'(resp_valid), 0);
      wait_start(gid, oa, ob);
      chk("t4_gid", 32'(gid), 0);
      tick();
      give_ready(oa, ob, rv, ry, re);
      chk("t4_rv", 32'(rv), 32'h1);
      req = '0;
      tick(); tick();

      // multiplier busy blocks the grant
      req = 4'b0100;
      mul_busy = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("t5_busy_gnt", 32'(gnt), 0);
         chk("t5_busy_start", 32'(mul_start), 0);
      end
      mul_busy = 1'b0;
      tick();
      chk("t5_gnt", 32'(gnt), 32'h4);
      wait_start(gid, oa, ob);
      tick();
      give_ready(oa, ob, rv, ry, re);
      chk("t5_rv", 32'(rv), 32'h4);
      req = '0;
      tick(); tick();

`ifdef FPMUL_ARB_TIMEOUT_EN
      // watchdog: no ready ever arrives
      req = 4'b0010;
      wait_start(gid, oa, ob);
      cnt = 0;
      while (resp_valid == '0 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("t6_latency", 32'(cnt), 32'(TO + 1));
      chk("t6_rv", 32'(resp_valid), 32'h2);
      chk("t6_y", resp_y, 32'h7F800001);
      chk("t6_err", 32'(resp_err), 1);
      req = 4'b1000;
      tick();
      chk("t6_err_clr", 32'(resp_err), 0);
      tick(); tick();
      chk("t6_busy_gnt", 32'(gnt), 0);
      mul_ready = 1'b1; mul_busy = 1'b0; mul_y = 32'h3F800000;
      tick();
      mul_ready = 1'b0;
      chk("t6_late_rv", 32'(resp_valid), 0);
      wait_start(gid, oa, ob);
      chk("t6_gid", 32'(gid), 3);
      tick();
      give_ready(oa, ob, rv, ry, re);
      chk("t6_rv2", 32'(rv), 32'h8);
      req = '0;
      tick(); tick();
`endif

      chk("final_err", 32'(resp_err), 0);
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
